// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: seven-segment glyph table,
// dash glyph for non-BCD codes, and the clog2 used for select widths.
package bcd_pkg;

   localparam logic [6:0] DASH = 7'h40;

   // Bit order {g,f,e,d,c,b,a}, active-high; codes 10..15 render as a dash
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, DASH,  DASH,  DASH,  DASH,  DASH,  DASH
   };

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high seven-segment pattern.
// Polarity is left to the instantiating scanner.
module bcd_to_7seg
   import bcd_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed seven-segment scanner: walks the counter's digits from the most
// significant down, samples each nibble after a guard cycle, and drives anodes.
module bcd_display_scan
   import bcd_pkg::*;
#(
   parameter  int N          = 3,
   parameter  int DWELL      = 50000,
   parameter  int BLANK_LZ   = 1,
   parameter  int ACTIVE_LOW = 1,
   localparam int SEL_W      = (clog2(N) < 1) ? 1 : clog2(N)
)(
   input  logic             clk,
   input  logic             rst,
   output logic [SEL_W-1:0] sel,
   input  logic [3:0]       dig_in,
   output logic [6:0]       seg,
   output logic [N-1:0]     an,
   output logic             frame
);

   localparam int               PRE_W    = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);
   localparam logic [N-1:0]     AN_OFF   = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
   localparam logic [6:0]       SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic             lz_q, lz_d;
   logic [6:0]       seg_q, seg_d;
   logic [N-1:0]     an_q, an_d;

   logic [6:0]       dec_seg;
   logic [N-1:0]     one_hot;
   logic             wrap;
   logic             guard;
   logic             eff_lz;
   logic             dig_zero;
   logic             blank;

   bcd_to_7seg u_dec (
      .bcd (dig_in),
      .seg (dec_seg)
   );

   always_comb begin
      one_hot = '0;
      for (int i = 0; i < N; i++) begin
         one_hot[i] = (idx_q == SEL_W'(i));
      end
   end

   assign wrap     = (pre_q == PRE_LAST);
   assign guard    = (pre_q == '0);
   assign dig_zero = (dig_in == 4'd0);
   // The most significant digit always starts a fresh leading-zero run
   assign eff_lz   = (idx_q == IDX_LAST) ? 1'b1 : lz_q;
   assign blank    = (BLANK_LZ != 0) && (idx_q != '0) && eff_lz && dig_zero;

   always_comb begin
      pre_d = wrap ? '0 : pre_q + 1'b1;
      idx_d = idx_q;
      lz_d  = lz_q;
      seg_d = seg_q;
      an_d  = an_q;
      if (wrap) begin
         idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
         // Dark anodes across the select change so the old segments never ghost
         an_d  = AN_OFF;
      end
      if (guard) begin
         seg_d = dec_seg ^ SEG_OFF;
         an_d  = blank ? AN_OFF : (one_hot ^ AN_OFF);
         lz_d  = eff_lz & dig_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         idx_q <= IDX_LAST;
         lz_q  <= 1'b1;
         seg_q <= SEG_OFF;
         an_q  <= AN_OFF;
      end else begin
         pre_q <= pre_d;
         idx_q <= idx_d;
         lz_q  <= lz_d;
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign sel   = idx_q;
   assign seg   = seg_q;
   assign an    = an_q;
   assign frame = wrap && (idx_q == '0);

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: three scanner variants share one
// modelled BCD counter; expected per-cycle outputs are queued and popped.
module tb_bcd_display_scan;

   localparam int DWELL = 4;

   logic       clk;
   logic       rst;
   logic [3:0] dh, dt, du;

   logic [1:0] sel_a, sel_n, sel_l;
   logic [3:0] dig_a, dig_n, dig_l;
   logic [6:0] seg_a, seg_n, seg_l;
   logic [2:0] an_a, an_n, an_l;
   logic       fr_a, fr_n, fr_l;

   int checks;
   int errors;
   logic [12:0] exp_q [$];

   function automatic logic [3:0] pick(input logic [1:0] s);
      return (s == 2'd2) ? dh : (s == 2'd1) ? dt : du;
   endfunction

   assign dig_a = pick(sel_a);
   assign dig_n = pick(sel_n);
   assign dig_l = pick(sel_l);

   bcd_display_scan #(.N(3), .DWELL(DWELL), .BLANK_LZ(1), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .sel(sel_a), .dig_in(dig_a), .seg(seg_a), .an(an_a), .frame(fr_a));

   bcd_display_scan #(.N(3), .DWELL(DWELL), .BLANK_LZ(0), .ACTIVE_LOW(0)) dut_nb (
      .clk(clk), .rst(rst), .sel(sel_n), .dig_in(dig_n), .seg(seg_n), .an(an_n), .frame(fr_n));

   bcd_display_scan #(.N(3), .DWELL(DWELL), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .sel(sel_l), .dig_in(dig_l), .seg(seg_l), .an(an_l), .frame(fr_l));

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // Expected {sel, an, seg, frame} for cycles counted from the first guard cycle
   task automatic gen_expected(input int start, input int n, input bit blz, input bit alow,
                               input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
      logic [3:0] dg [3];
      int d, p, pd;
      bit lit;
      logic [2:0] an_e;
      logic [6:0] seg_e;
      logic fr_e;
      dg[0] = u; dg[1] = t; dg[2] = h;
      for (int c = start; c < start + n; c++) begin
         d  = 2 - (c / DWELL) % 3;
         p  = c % DWELL;
         pd = (d == 2) ? 0 : d + 1;
         lit = 1'b1;
         if (blz && d != 0) begin
            lit = 1'b0;
            for (int k = d; k < 3; k++) if (dg[k] != 4'd0) lit = 1'b1;
         end
         an_e  = (p == 0 || !lit) ? 3'b000 : 3'(1 << d);
         seg_e = (p != 0) ? seg7(dg[d]) : (c == 0) ? 7'h00 : seg7(dg[pd]);
         fr_e  = (p == DWELL - 1) && (d == 0);
         if (alow) begin
            an_e  = ~an_e;
            seg_e = ~seg_e;
         end
         exp_q.push_back({2'(d), an_e, seg_e, fr_e});
      end
   endtask

   // Leaves the bench at the negedge of the first post-reset (guard) cycle
   task automatic start_scan();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      dh = 4'd1; dt = 4'd0; du = 4'd5;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== {2'd2, 3'b000, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_high got %h required %h", {sel_a, an_a, seg_a, fr_a}, {2'd2, 3'b000, 7'h00, 1'b0});
         end
         checks++;
         if ({sel_l, an_l, seg_l, fr_l} !== {2'd2, 3'b111, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_low got %h required %h", {sel_l, an_l, seg_l, fr_l}, {2'd2, 3'b111, 7'h7F, 1'b0});
         end
      end
   endtask

   task automatic test_basic();
      logic [12:0] e;
      dh = 4'd1; dt = 4'd0; du = 4'd5;
      gen_expected(0, 24, 1'b1, 1'b0, dh, dt, du);
      start_scan();
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL basic c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
      end
   endtask

   task automatic test_blanking();
      logic [12:0] e;
      dh = 4'd0; dt = 4'd0; du = 4'd7;
      gen_expected(0, 12, 1'b1, 1'b0, dh, dt, du);
      start_scan();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL blank_007 c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
      end
      gen_expected(0, 12, 1'b0, 1'b0, dh, dt, du);
      start_scan();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_n, an_n, seg_n, fr_n} !== e) begin
            errors++;
            $display("FAIL noblank_007 c=%0d got %h required %h", c, {sel_n, an_n, seg_n, fr_n}, e);
         end
      end
   endtask

   task automatic test_all_zero();
      logic [12:0] e;
      dh = 4'd0; dt = 4'd0; du = 4'd0;
      gen_expected(0, 12, 1'b1, 1'b0, dh, dt, du);
      start_scan();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL all_zero c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
      end
   endtask

   task automatic test_invalid();
      logic [12:0] e;
      dh = 4'd1; dt = 4'hC; du = 4'd5;
      gen_expected(0, 12, 1'b1, 1'b0, dh, dt, du);
      start_scan();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL invalid c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [12:0] e;
      dh = 4'd1; dt = 4'd0; du = 4'd5;
      gen_expected(0, 7, 1'b1, 1'b0, dh, dt, du);
      start_scan();
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL pre_reset c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({sel_a, an_a, seg_a, fr_a} !== {2'd2, 3'b000, 7'h00, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset got %h required %h", {sel_a, an_a, seg_a, fr_a}, {2'd2, 3'b000, 7'h00, 1'b0});
      end
      rst = 1'b0;
      gen_expected(0, 12, 1'b1, 1'b0, dh, dt, du);
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL restart c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
      end
   endtask

   task automatic test_active_low();
      logic [12:0] e;
      dh = 4'd1; dt = 4'd0; du = 4'd5;
      gen_expected(0, 12, 1'b1, 1'b1, dh, dt, du);
      start_scan();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_l, an_l, seg_l, fr_l} !== e) begin
            errors++;
            $display("FAIL active_low c=%0d got %h required %h", c, {sel_l, an_l, seg_l, fr_l}, e);
         end
      end
   endtask

   // Counter value changes between frames; units digit kept so the guard-cycle seg carries over
   task automatic test_back_to_back();
      logic [12:0] e;
      dh = 4'd1; dt = 4'd0; du = 4'd5;
      gen_expected(0, 12, 1'b1, 1'b0, 4'd1, 4'd0, 4'd5);
      gen_expected(12, 12, 1'b1, 1'b0, 4'd0, 4'd3, 4'd5);
      start_scan();
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({sel_a, an_a, seg_a, fr_a} !== e) begin
            errors++;
            $display("FAIL back_to_back c=%0d got %h required %h", c, {sel_a, an_a, seg_a, fr_a}, e);
         end
         if (c == 11) begin
            dh = 4'd0;
            dt = 4'd3;
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      dh = 4'd0; dt = 4'd0; du = 4'd0;
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_blanking();
      test_all_zero();
      test_invalid();
      test_mid_reset();
      test_active_low();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed seven-segment display scanner that reads an N-digit BCD counter one digit at a time. It drives the counter's digit-select input, samples the returned BCD nibble, decodes it, and time-multiplexes the digit anodes, with optional leading-zero blanking. It sits between the BCD counter's select/digit port and the board's common-anode/cathode display pins.

## Interface
- `N`, 3: number of digits; must equal the counter's digit count; N ≥ 1.
- `DWELL`, 50000: clock cycles each digit is addressed (dwell period); DWELL ≥ 2.
- `BLANK_LZ`, 1: 1 enables leading-zero blanking. Digit 0 is never blanked.
- `ACTIVE_LOW`, 1: 1 inverts both `seg` and `an`, so the active level is 0.
- SEL_W: derived, max(1, ceil(log2 N)).

- `clk` in 1: sole clock. All logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sel` out SEL_W: digit index presented to the counter. Registered.
- `dig_in` in 4: BCD nibble returned by the counter for `sel`. It is combinational from `sel` on the counter side.
- `seg` out 7: segments, bit order {g,f,e,d,c,b,a}. Registered.
- `an` out N: one-hot digit enable; `an[i]` selects digit i. Registered.
- `frame` out 1: one-cycle pulse when the scan wraps from digit 0 back to N-1.

## Operation
- Internal state:
  - `pre`: 0..DWELL-1 prescaler.
  - `idx`: current digit, 0..N-1.
  - `lz`: "all higher digits zero so far".
- Scan order is descending: N-1, N-2, …, 0, then back to N-1. `sel` = `idx` at all times.
- `pre` increments every cycle and wraps at DWELL-1 → 0. On that wrap cycle:
  - `idx` decrements.
  - When `idx`=0, `idx` wraps to N-1 and `frame`=1 for that cycle.
- Dwell cycle `pre`=0 is the guard cycle:
  - `an` is driven all-inactive during this cycle to suppress ghosting.
  - At the end of this cycle, `dig_in` is sampled.
- Sample action at the edge ending `pre`=0:
  - `seg` ← decode(`dig_in`).
  - `an` ← onehot(`idx`), unless the digit is blanked, in which case `an` is all-inactive.
  - If `idx`=N-1, `lz` is first treated as 1.
  - Next `lz` ← `lz` & (`dig_in`==0).
- Blanked condition: BLANK_LZ=1 and `idx`≠0 and effective `lz`=1 and `dig_in`==0.
- Decode table, in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - Invalid codes 10–15 → 40 (dash, segment g only).
- Polarity: ACTIVE_LOW=1 inverts the final `seg` and `an` registers. All inactive levels follow this inversion.
- Reset values:
  - `pre`=0, `idx`=N-1, `sel`=N-1, `lz`=1.
  - `an` all inactive, `seg` all inactive, `frame`=0.
  - The first post-reset cycle is a guard cycle.
- N=1: `idx` stays 0, and `frame` pulses every DWELL cycles.

## Timing
- `sel` changes at the edge ending a dwell. `dig_in` must settle within that same cycle (`pre`=0).
- From a `sel` change to the corresponding `an`/`seg` update: 1 cycle.
- Each digit is lit for DWELL-1 cycles. Full refresh period is N·DWELL cycles.
- `frame` is asserted in the same cycle that `idx` transitions 0 → N-1.
- `rst` mid-dwell takes effect on the next edge. State returns to the reset values with no partial-dwell carry-over.
- `dig_in` changing mid-dwell (the counter incrementing) is not reflected until that digit's next sample.

## Structure
- Shared package `bcd_pkg` holds:
  - The 16-entry seven-segment constant table.
  - The DASH constant (7'h40).
  - A `clog2` function used for SEL_W. The counter uses the same function.
- One sub-module, `bcd_to_7seg`: combinational 4-bit → 7-bit decoder, instantiated once. Polarity inversion is applied in `bcd_display_scan`, not in the decoder.

## Test plan
Default bench parameters: N=3, DWELL=4, ACTIVE_LOW=0, BLANK_LZ=1. The bench models the counter mux as `dig_in` = digits[`sel`].

1. Digits {1,0,5} (hundreds..units), release `rst`:
   - `sel` sequence 2,1,0 with 4 cycles each.
   - `an`=100 with `seg`=06, then 010 with 3F, then 001 with 6D.
   - `an`=000 on every guard cycle.
   - `frame` pulses every 12 cycles.
2. Digits {0,0,7}:
   - Hundreds and tens blanked, so `an`=000 in those dwells.
   - Units shown: `an`=001, `seg`=07.
   - With BLANK_LZ=0, all three digits are shown, with `seg`=3F,3F,07.
3. Digits {0,0,0}: only units lit, `an`=001, `seg`=3F. Hundreds and tens are dark.
4. Digit 1 forced to 4'hC: tens dwell shows `seg`=40 with `an`=010.
5. Assert `rst` on cycle 6 (mid tens dwell):
   - Next cycle: `sel`=2, `an`=000, `seg`=00, `frame`=0.
   - Scan restarts at hundreds, 1 cycle after `rst` deasserts.
6. ACTIVE_LOW=1 with case 1 digits: `an` values 011/101/110 and `seg` values 79/40/12. Guard cycles show `an`=111.
